// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: pending-write scoreboard for long-latency GPR producers; holds issue on RAW/WAW/full.
// Optional saturating stall counter enabled by HAZARD_SCOREBOARD_STALL_CNT_EN.
module hazard_scoreboard #(
    parameter int REG_ADDR_W      = 5,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3,
    localparam int NUM_REGS       = 2**REG_ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rs,
    input  logic [REG_ADDR_W-1:0] issue_rt,
    input  logic                  issue_rs_use,
    input  logic                  issue_rt_use,
    input  logic [REG_ADDR_W-1:0] issue_dst,
    input  logic                  issue_long,
    output logic                  issue_ready,
    input  logic                  comp_valid,
    input  logic [REG_ADDR_W-1:0] comp_dst,
    input  logic                  flush,
    output logic                  stall,
    output logic                  stall_raw,
    output logic                  stall_waw,
    output logic                  stall_full,
    output logic [NUM_REGS-1:0]   pending,
    output logic [CNT_W-1:0]      pending_count,
    output logic                  busy,
    output logic                  comp_err,
    output logic [31:0]           stall_cycles
);
    logic [NUM_REGS-1:0] pending_q, pending_d, comp_oh, alloc_oh, eff;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                comp_err_q, comp_err_d;
    logic                comp_hit, raw, waw, full, alloc, dst_nz;

    // eff bypasses a same-cycle write-back so dependents issue in the completion cycle
    always_comb begin
        comp_oh     = comp_valid ? NUM_REGS'(1) << comp_dst : '0;
        eff         = pending_q & ~comp_oh;
        comp_hit    = comp_valid & pending_q[comp_dst];
        dst_nz      = issue_dst != '0;
        raw         = (issue_rs_use & eff[issue_rs]) | (issue_rt_use & eff[issue_rt]);
        waw         = issue_long & dst_nz & eff[issue_dst];
        full        = issue_long & dst_nz & ((count_q - CNT_W'(comp_hit)) == CNT_W'(MAX_OUTSTANDING));
        issue_ready = ~flush & ~raw & ~waw & ~full;
        alloc       = issue_valid & issue_ready & issue_long & dst_nz;
        alloc_oh    = alloc ? NUM_REGS'(1) << issue_dst : '0;
        pending_d   = flush ? '0 : eff | alloc_oh;
        count_d     = flush ? '0 : count_q + CNT_W'(alloc) - CNT_W'(comp_hit);
        comp_err_d  = ~flush & comp_valid & ~comp_hit;
        stall       = issue_valid & ~issue_ready;
        stall_raw   = issue_valid & raw;
        stall_waw   = issue_valid & waw;
        stall_full  = issue_valid & full;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_q  <= '0;
            count_q    <= '0;
            comp_err_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            count_q    <= count_d;
            comp_err_q <= comp_err_d;
        end
    end

    assign pending       = pending_q;
    assign pending_count = count_q;
    assign busy          = count_q != '0;
    assign comp_err      = comp_err_q;

`ifdef HAZARD_SCOREBOARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    always_comb stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) stall_cnt_q <= '0;
        else stall_cnt_q <= stall_cnt_d;
    end
    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scoreboard bench for hazard_scoreboard.
module tb_hazard_scoreboard;
    logic        clock, reset;
    logic        issue_valid, issue_rs_use, issue_rt_use, issue_long, issue_ready;
    logic [4:0]  issue_rs, issue_rt, issue_dst, comp_dst;
    logic        comp_valid, flush;
    logic        stall, stall_raw, stall_waw, stall_full, busy, comp_err;
    logic [31:0] pending, stall_cycles;
    logic [2:0]  pending_count;

    hazard_scoreboard dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
        .issue_rs_use(issue_rs_use), .issue_rt_use(issue_rt_use),
        .issue_dst(issue_dst), .issue_long(issue_long), .issue_ready(issue_ready),
        .comp_valid(comp_valid), .comp_dst(comp_dst), .flush(flush),
        .stall(stall), .stall_raw(stall_raw), .stall_waw(stall_waw), .stall_full(stall_full),
        .pending(pending), .pending_count(pending_count), .busy(busy),
        .comp_err(comp_err), .stall_cycles(stall_cycles)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          errs = 0;
    logic        exp_stall = 1'b0;
    logic [31:0] stall_model = '0;

    always @(posedge clock or posedge reset)
        if (reset) stall_model <= '0;
        else if (exp_stall && stall_model != 32'hFFFF_FFFF) stall_model <= stall_model + 32'd1;

    function automatic logic [31:0] exp_sc();
`ifdef HAZARD_SCOREBOARD_STALL_CNT_EN
        return stall_model;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] observe(input string t);
        if (t == "ready") return {31'd0, issue_ready};
        if (t == "stall") return {31'd0, stall};
        if (t == "raw") return {31'd0, stall_raw};
        if (t == "waw") return {31'd0, stall_waw};
        if (t == "full") return {31'd0, stall_full};
        if (t == "pending") return pending;
        if (t == "count") return {29'd0, pending_count};
        if (t == "busy") return {31'd0, busy};
        if (t == "comp_err") return {31'd0, comp_err};
        if (t == "stall_cycles") return stall_cycles;
        return 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input string t, input logic [31:0] v);
        exp_t e;
        e.tag = t;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            chk(e.tag, observe(e.tag), e.exp);
        end
    endtask

    task automatic stall_is(input logic v);
        exp_stall = v;
        push("stall", {31'd0, v});
    endtask

    task automatic idle();
        issue_valid = 0; issue_long = 0; issue_dst = 0;
        issue_rs = 0; issue_rs_use = 0; issue_rt = 0; issue_rt_use = 0;
        comp_valid = 0; comp_dst = 0; flush = 0;
        exp_stall = 0;
    endtask

    task automatic iss(input logic lng, input logic [4:0] dst, input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rt, input logic rtu);
        issue_valid = 1; issue_long = lng; issue_dst = dst;
        issue_rs = rs; issue_rs_use = rsu; issue_rt = rt; issue_rt_use = rtu;
    endtask

    task automatic comp(input logic [4:0] d);
        comp_valid = 1;
        comp_dst = d;
    endtask

    task automatic nxt();
        @(negedge clock);
        idle();
    endtask

    initial begin
        reset = 1;
        idle();
        @(negedge clock);
        #1;
        push("pending", 0); push("count", 0); push("busy", 0);
        push("comp_err", 0); push("stall_cycles", 0); push("ready", 1);
        drain();
        reset = 0;

        // RAW on rs, held, then resolved by same-cycle completion
        nxt(); iss(1, 8, 0, 0, 0, 0); push("ready", 1); #1 drain();
        nxt(); iss(0, 0, 8, 1, 0, 0);
        push("pending", 32'h100); push("count", 1); push("busy", 1);
        push("ready", 0); push("raw", 1); stall_is(1); #1 drain();
        repeat (10) @(negedge clock);
        #1;
        push("stall_cycles", exp_sc()); drain();
        comp(8); stall_is(0); push("ready", 1); push("raw", 0); #1 drain();
        nxt(); push("pending", 0); push("count", 0); push("comp_err", 0);
        push("stall_cycles", exp_sc()); #1 drain();

        // RAW on rt, gated by rt_use
        nxt(); iss(1, 8, 0, 0, 0, 0); push("ready", 1); #1 drain();
        nxt(); iss(0, 0, 0, 0, 8, 1); push("ready", 0); push("raw", 1); stall_is(1); #1 drain();
        nxt(); iss(0, 0, 0, 0, 8, 0); push("ready", 1); #1 drain();
        nxt(); comp(8);
        nxt(); push("pending", 0); push("comp_err", 0); #1 drain();

        // r0 never allocates and never hazards
        nxt(); iss(1, 0, 0, 0, 0, 0); push("ready", 1); #1 drain();
        nxt(); iss(0, 0, 0, 1, 0, 1);
        push("pending", 0); push("count", 0); push("ready", 1); stall_is(0); #1 drain();

        // fill to MAX_OUTSTANDING, full stall relieved by same-cycle completion
        for (int d = 1; d <= 4; d++) begin
            nxt(); iss(1, 5'(d), 0, 0, 0, 0); push("ready", 1); #1 drain();
        end
        nxt(); iss(1, 5, 0, 0, 0, 0);
        push("count", 4); push("busy", 1); push("pending", 32'h1E);
        push("ready", 0); push("full", 1); stall_is(1); #1 drain();
        comp(2); stall_is(0); push("ready", 1); push("full", 0); #1 drain();
        nxt(); comp(5); push("count", 4); push("pending", 32'h3A); push("comp_err", 0); #1 drain();

        // alloc and complete of the same register: set wins, count unchanged
        nxt(); iss(1, 9, 0, 0, 0, 0); push("pending", 32'h1A); push("count", 3); push("ready", 1); #1 drain();
        nxt(); iss(1, 9, 0, 0, 0, 0); comp(9);
        push("pending", 32'h21A); push("count", 4); push("ready", 1); push("waw", 0); #1 drain();
        nxt(); iss(1, 9, 0, 0, 0, 0);
        push("pending", 32'h21A); push("count", 4); push("comp_err", 0);
        push("ready", 0); push("waw", 1); push("full", 1); stall_is(1); #1 drain();
        nxt(); comp(9); push("count", 4); #1 drain();

        // flush overrides alloc/complete and suppresses comp_err
        nxt(); flush = 1; iss(1, 6, 0, 0, 0, 0); comp(3);
        push("pending", 32'h1A); push("count", 3);
        push("ready", 0); push("raw", 0); push("waw", 0); push("full", 0); stall_is(1); #1 drain();
        nxt(); comp(7);
        push("pending", 0); push("count", 0); push("busy", 0); push("comp_err", 0); #1 drain();
        nxt(); comp(0); push("comp_err", 1); #1 drain();
        nxt(); push("comp_err", 1); push("stall_cycles", exp_sc()); #1 drain();
        nxt(); push("comp_err", 0); #1 drain();

        // asynchronous reset during a RAW stall
        nxt(); iss(1, 8, 0, 0, 0, 0); #1 drain();
        nxt(); iss(0, 0, 8, 1, 0, 0); push("raw", 1); stall_is(1); #1 drain();
        #2 reset = 1;
        #1;
        push("pending", 0); push("count", 0); push("busy", 0); push("comp_err", 0);
        push("stall_cycles", 0); push("raw", 0); stall_is(0);
        drain();
        nxt(); reset = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
